// File: rtl/uart_rx_io_if.sv
// IO bus bundle between the CPU-side register decoder and the UART receiver.
// The master drives address and read strobe; the slave returns data and the interrupt.
interface uart_rx_io_if;
    logic [13:0] IO_wordAddr_i;
    logic        IO_memRd_i;
    logic [31:0] IO_memRData_o;
    logic        rx_irq_o;

    modport master (
        output IO_wordAddr_i,
        output IO_memRd_i,
        input  IO_memRData_o,
        input  rx_irq_o
    );

    modport slave (
        input  IO_wordAddr_i,
        input  IO_memRd_i,
        output IO_memRData_o,
        output rx_irq_o
    );
endinterface

// File: rtl/uart_rx_io.sv
// 8N1 UART receiver with a small circular receive FIFO and two memory-mapped
// registers: RX_DAT (head byte, pops on read) and RX_STAT (flags, clear on read).
module uart_rx_io #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int RX_DAT_bit   = 3,
    parameter int RX_STAT_bit  = 4
) (
    input  logic          clk_i,
    input  logic          resetn_i,
    input  logic          rxd_i,
    uart_rx_io_if.slave   io
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT + 1);

    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    // Line synchronizer, reset to the idle-high level
    logic r_rxd_meta;
    logic r_rxd_sync;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd_i;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    state_t           r_state;
    logic [TMR_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;

    logic w_cnt_zero;
    logic w_stop_sample;
    logic w_push;
    logic w_frame_evt;

    assign w_cnt_zero    = (r_clk_cnt == '0);
    assign w_stop_sample = (r_state == S_STOP) && w_cnt_zero;
    assign w_push        = w_stop_sample &&  r_rxd_sync;
    assign w_frame_evt   = w_stop_sample && !r_rxd_sync;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxd_sync) begin
                        r_state   <= S_START;
                        r_clk_cnt <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (!w_cnt_zero) begin
                        r_clk_cnt <= r_clk_cnt - 1'b1;
                    end else if (!r_rxd_sync) begin
                        r_state   <= S_DATA;
                        r_clk_cnt <= FULL_LOAD;
                        r_bit_idx <= '0;
                    end else begin
                        r_state <= S_IDLE;  // too short to be a start bit
                    end
                end
                S_DATA: begin
                    if (!w_cnt_zero) begin
                        r_clk_cnt <= r_clk_cnt - 1'b1;
                    end else begin
                        r_shift   <= {r_rxd_sync, r_shift[7:1]};
                        r_clk_cnt <= FULL_LOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (!w_cnt_zero) begin
                        r_clk_cnt <= r_clk_cnt - 1'b1;
                    end else begin
                        r_state <= r_rxd_sync ? S_IDLE : S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_rxd_sync) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register decode
    logic w_sel_dat;
    logic w_sel_stat;
    logic w_stat_clr;
    logic w_not_empty;
    logic w_full;
    logic w_pop;
    logic w_push_acc;
    logic w_ovr_set;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic             r_overrun;
    logic             r_frame_err;

    assign w_sel_dat   = io.IO_wordAddr_i[RX_DAT_bit];
    assign w_sel_stat  = io.IO_wordAddr_i[RX_STAT_bit];
    assign w_stat_clr  = io.IO_memRd_i && w_sel_stat;
    assign w_not_empty = (r_count != '0);
    assign w_full      = (r_count == DEPTH_CNT);
    assign w_pop       = io.IO_memRd_i && w_sel_dat && w_not_empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push_acc  = w_push && (!w_full || w_pop);
    assign w_ovr_set   = w_push && w_full && !w_pop;

    // NOTE: FIFO storage has no reset; the count and pointers alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_acc, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Set wins over clear-on-read so no event is lost
            r_overrun   <= w_ovr_set   || (r_overrun   && !w_stat_clr);
            r_frame_err <= w_frame_evt || (r_frame_err && !w_stat_clr);
        end
    end

    logic [31:0] w_dat_val;
    logic [31:0] w_stat_val;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_dat_val  = 32'b0;
        w_stat_val = 32'b0;
        if (w_sel_dat && w_not_empty) begin
            w_dat_val = {24'b0, r_mem[r_rd_ptr]};
        end
        if (w_sel_stat) begin
            w_stat_val = {28'b0, w_full, r_overrun, r_frame_err, w_not_empty};
        end
    end

    assign io.IO_memRData_o = w_dat_val | w_stat_val;
    assign io.rx_irq_o      = w_not_empty;

endmodule

// File: tb/tb_uart_rx_io.sv
// Self-checking bench for uart_rx_io: directed frame scenarios plus randomized
// traffic against a queue-based model of the receive FIFO and status flags.
module tb_uart_rx_io;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    localparam logic [13:0] A_DAT  = 14'h0008;
    localparam logic [13:0] A_STAT = 14'h0010;
    localparam logic [13:0] A_BOTH = 14'h0018;
    localparam logic [13:0] A_NONE = 14'h0004;

    logic clk;
    logic rst_n;
    logic rxd;

    uart_rx_io_if bus ();

    uart_rx_io #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .RX_DAT_bit   (3),
        .RX_STAT_bit  (4)
    ) dut (
        .clk_i    (clk),
        .resetn_i (rst_n),
        .rxd_i    (rxd),
        .io       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: received bytes in arrival order plus sticky flags
    logic [7:0] m_q[$];
    logic       m_ovr;
    logic       m_ferr;

    function automatic logic [31:0] model_rdata(input logic [13:0] addr);
        logic [31:0] v;
        v = 32'b0;
        if (addr[3] && m_q.size() != 0) v = v | {24'b0, m_q[0]};
        if (addr[4]) v = v | {28'b0, m_q.size() == DEPTH, m_ovr, m_ferr, m_q.size() != 0};
        return v;
    endfunction

    task automatic model_side(input logic [13:0] addr);
        if (addr[3] && m_q.size() != 0) void'(m_q.pop_front());
        if (addr[4]) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic good);
        if (!good)                   m_ferr = 1'b1;
        else if (m_q.size() < DEPTH) m_q.push_back(b);
        else                         m_ovr  = 1'b1;
    endtask

    // Drives one 8N1 frame; stop_low_clks > 0 holds the stop bit low that long.
    task automatic send_frame(input logic [7:0] b, input int stop_low_clks);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_low_clks > 0) begin
            rxd = 1'b0;
            repeat (stop_low_clks) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CPB + 4) @(negedge clk);
    endtask

    task automatic io_read(input logic [13:0] addr, input logic rd, output logic [31:0] data);
        @(negedge clk);
        bus.IO_wordAddr_i = addr;
        bus.IO_memRd_i    = rd;
        #1 data = bus.IO_memRData_o;
        @(posedge clk);
        #1;
        bus.IO_memRd_i    = 1'b0;
        bus.IO_wordAddr_i = '0;
    endtask

    task automatic test_reset();
        logic [13:0] addrs [4];
        addrs = '{A_DAT, A_STAT, A_BOTH, A_NONE};
        rst_n = 1'b0;
        rxd   = 1'b1;
        bus.IO_memRd_i    = 1'b0;
        bus.IO_wordAddr_i = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.IO_wordAddr_i = addrs[i];
            #1;
            n_checks++;
            if (bus.IO_memRData_o !== 32'b0) begin
                n_errors++;
                $display("FAIL reset_rdata addr=%h: got %h expected 00000000", addrs[i], bus.IO_memRData_o);
            end
        end
        n_checks++;
        if (bus.rx_irq_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_irq: got %b expected 0", bus.rx_irq_o);
        end
        bus.IO_wordAddr_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] got;
        bus.IO_wordAddr_i = A_STAT;
        fork
            send_frame(8'hA5, 0);
            begin
                @(negedge clk);
                repeat (9 * CPB + CPB / 2 + 2) @(posedge clk);
                #1;
                n_checks++;
                if (bus.IO_memRData_o !== 32'h0) begin
                    n_errors++;
                    $display("FAIL push_early: got %h expected 00000000", bus.IO_memRData_o);
                end
                @(posedge clk);
                #1;
                n_checks++;
                if (bus.IO_memRData_o !== 32'h1) begin
                    n_errors++;
                    $display("FAIL push_latency: got %h expected 00000001", bus.IO_memRData_o);
                end
            end
        join
        n_checks++;
        if (bus.rx_irq_o !== 1'b1) begin
            n_errors++;
            $display("FAIL a5_irq: got %b expected 1", bus.rx_irq_o);
        end
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h1) begin
            n_errors++;
            $display("FAIL a5_stat: got %h expected 00000001", got);
        end
        io_read(A_DAT, 1'b1, got);
        n_checks++;
        if (got !== 32'hA5) begin
            n_errors++;
            $display("FAIL a5_dat: got %h expected 000000a5", got);
        end
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h0 || bus.rx_irq_o !== 1'b0) begin
            n_errors++;
            $display("FAIL a5_after_pop: got stat %h irq %b expected 00000000 irq 0", got, bus.rx_irq_o);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] got;
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h0 || bus.rx_irq_o !== 1'b0) begin
            n_errors++;
            $display("FAIL glitch: got stat %h irq %b expected 00000000 irq 0", got, bus.rx_irq_o);
        end
    endtask

    task automatic test_frame_err();
        logic [31:0] got;
        send_frame(8'h3C, 40);
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h2) begin
            n_errors++;
            $display("FAIL frame_err_stat: got %h expected 00000002", got);
        end
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h0) begin
            n_errors++;
            $display("FAIL frame_err_clear: got %h expected 00000000", got);
        end
        send_frame(8'h5A, 0);
        io_read(A_DAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h5A) begin
            n_errors++;
            $display("FAIL after_break_dat: got %h expected 0000005a", got);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] got;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 0);
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'hD) begin
            n_errors++;
            $display("FAIL overrun_stat: got %h expected 0000000d", got);
        end
        for (int i = 1; i <= 5; i++) begin
            io_read(A_DAT, 1'b1, got);
            n_checks++;
            if (got !== ((i <= DEPTH) ? 32'(i) : 32'h0)) begin
                n_errors++;
                $display("FAIL overrun_drain[%0d]: got %h expected %h", i, got, (i <= DEPTH) ? 32'(i) : 32'h0);
            end
        end
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h0) begin
            n_errors++;
            $display("FAIL overrun_cleared: got %h expected 00000000", got);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] got;
        for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 0);
        fork
            send_frame(8'h14, 0);
            begin
                @(negedge clk);
                repeat (9 * CPB + CPB / 2 + 2) @(posedge clk);
                @(negedge clk);
                bus.IO_wordAddr_i = A_DAT;
                bus.IO_memRd_i    = 1'b1;
                #1 got = bus.IO_memRData_o;
                @(posedge clk);
                #1;
                bus.IO_memRd_i    = 1'b0;
                bus.IO_wordAddr_i = '0;
                n_checks++;
                if (got !== 32'h10) begin
                    n_errors++;
                    $display("FAIL full_pop_head: got %h expected 00000010", got);
                end
            end
        join
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h9) begin
            n_errors++;
            $display("FAIL full_pop_stat: got %h expected 00000009", got);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            io_read(A_DAT, 1'b1, got);
            n_checks++;
            if (got !== 32'h10 + 32'(i)) begin
                n_errors++;
                $display("FAIL full_pop_order[%0d]: got %h expected %h", i, got, 32'h10 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] got;
        logic [7:0]  b;
        b = 8'h77;
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = b[4];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rxd   = 1'b1;
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_checks++;
        if (bus.rx_irq_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid_irq: got %b expected 0", bus.rx_irq_o);
        end
        send_frame(8'h12, 0);
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h1) begin
            n_errors++;
            $display("FAIL reset_mid_stat: got %h expected 00000001", got);
        end
        io_read(A_DAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h12) begin
            n_errors++;
            $display("FAIL reset_mid_dat: got %h expected 00000012", got);
        end
        io_read(A_STAT, 1'b1, got);
        n_checks++;
        if (got !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_mid_empty: got %h expected 00000000", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] exp;
        logic [7:0]  b;
        logic        good;
        logic [13:0] addr;
        int          mode;
        m_q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        for (int i = 0; i < 14; i++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_frame(b, good ? 0 : 24);
            model_frame(b, good);
            mode = $urandom_range(0, 3);
            addr = (mode == 0) ? A_NONE : (mode == 1) ? A_DAT : (mode == 2) ? A_STAT : A_BOTH;
            exp  = model_rdata(addr);
            io_read(addr, 1'b1, got);
            model_side(addr);
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random[%0d] addr=%h: got %h expected %h", i, addr, got, exp);
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            exp = model_rdata(A_BOTH);
            io_read(A_BOTH, 1'b1, got);
            model_side(A_BOTH);
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL random_drain[%0d]: got %h expected %h", i, got, exp);
            end
        end
        n_checks++;
        if (bus.rx_irq_o !== 1'b0) begin
            n_errors++;
            $display("FAIL random_final_irq: got %b expected 0", bus.rx_irq_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_full_pop();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_io.md
UART_RX_IO -- requirements
Module: uart_rx_io

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clocks per UART bit (115200 baud at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter RX_DAT_bit, default 3, IO word-address bit selecting the data register.
REQ-004 SHALL have parameter RX_STAT_bit, default 4, IO word-address bit selecting the status register.
REQ-005 SHALL have port clk_i, input, 1, the single clock; all state on its rising edge.
REQ-006 SHALL have port resetn_i, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rxd_i, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port IO_wordAddr_i, input, 14, IO word address (byte address bits 15:2).
REQ-009 SHALL have port IO_memRd_i, input, 1, read strobe, one cycle per access.
REQ-010 SHALL have port IO_memRData_o, output, 32, read data, combinational from address.
REQ-011 SHALL have port rx_irq_o, output, 1, high while FIFO non-empty.

Function
REQ-012 SHALL pass rxd_i through a 2-flop synchronizer before any use.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: synced line low -> START, bit counter loaded with CLKS_PER_BIT/2-1.
REQ-015 START: at counter zero, line low -> DATA (counter CLKS_PER_BIT-1); line high -> IDLE, glitch ignored, no flags.
REQ-016 DATA: sample every CLKS_PER_BIT clocks, 8 bits LSB first, then STOP.
REQ-017 STOP: sample after CLKS_PER_BIT clocks; high -> push byte, IDLE; low -> discard byte, set frame_err, WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until synced line high (break tolerated), then IDLE.
REQ-019 SHALL start START-bit timing on the cycle the synced line is first low; stop-bit sample at 9.5*CLKS_PER_BIT (floor) clocks later.
REQ-020 Pushed byte SHALL be readable on the cycle after the stop-bit sample edge.
REQ-021 FIFO SHALL be circular, pointers wrap modulo FIFO_DEPTH, count width clog2(FIFO_DEPTH)+1.
REQ-022 Push when full and no pop SHALL drop the new byte, set overrun; FIFO contents unchanged.
REQ-023 Push and pop in the same cycle SHALL both occur, count unchanged, no overrun, including when full.
REQ-024 RX_DAT read (IO_wordAddr_i[RX_DAT_bit]) SHALL return {24'b0, head byte}; 32'b0 if empty.
REQ-025 RX_DAT read with IO_memRd_i high and FIFO non-empty SHALL pop at that edge; read when empty has no effect.
REQ-026 RX_STAT read SHALL return {28'b0, full, overrun, frame_err, not_empty}.
REQ-027 RX_STAT read with IO_memRd_i high SHALL clear overrun and frame_err at that edge; returned value is pre-clear.
REQ-028 Flag set event coinciding with its clear SHALL leave the flag set.
REQ-029 Neither bit selected SHALL drive IO_memRData_o 32'b0; both selected SHALL return RX_DAT OR RX_STAT and apply both side effects.
REQ-030 rx_irq_o SHALL equal not_empty, registered-state derived, no glitch on reads.

Reset
REQ-031 Reset low SHALL immediately force: FSM IDLE, synchronizer flops 1, FIFO empty, pointers 0, overrun 0, frame_err 0, counters 0.
REQ-032 Reset mid-frame SHALL abort the frame without pushing or flagging; after release, first falling edge starts a new frame.
REQ-033 After reset IO_memRData_o SHALL be 32'b0 for any address and rx_irq_o 0.

Verification (bench CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-034 Frame 0xA5, valid stop -> STAT reads 0x1, DAT reads 0xA5, pop -> STAT 0x0, irq low.
REQ-035 Start pulse low 4 clocks then high -> stays IDLE, STAT 0x0, no push.
REQ-036 Frame 0x3C with stop bit low held 40 clocks -> no push, STAT 0x2; STAT read clears -> next read 0x0.
REQ-037 Send 0x01..0x05 without reads -> STAT 0xD (full, overrun, not_empty); DAT pops 0x01,0x02,0x03,0x04, then empty.
REQ-038 FIFO full, DAT pop on same edge as 5th byte push -> count stays 4, overrun 0, order preserved.
REQ-039 resetn_i low at DATA bit 4 of 0x77, release, send 0x12 -> only 0x12 in FIFO, flags 0.
